// File: rtl/pipe_elastic_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage registers.
//   PIPE_MAX_DEPTH   largest supported buffer depth
//   ptr_inc()        wrapping pointer increment for any depth 1..PIPE_MAX_DEPTH
//   *_t              packed per-boundary stage-state words; instances size
//                    their WIDTH parameter from $bits() of these
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int PIPE_MAX_DEPTH = 8;

   // Wraps at depth-1 back to 0, so non-power-of-two depths are legal.
   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      if (ptr >= depth - 1) begin
         return 0;
      end
      return ptr + 1;
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_val;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_val;
      logic [4:0]  rd;
      logic        reg_wr;
   } mem_wb_t;

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// -----------------------------------------------------------------------------
// pipe_elastic_stage_if
// One valid/ready/data channel between two pipeline stages.
//   valid  producer has a word on data
//   ready  consumer accepts the word this cycle
//   data   WIDTH-bit stage-state word
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pipe_elastic_stage_if
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/pipe_elastic_stage_ptr_ctr.sv
// -----------------------------------------------------------------------------
// pipe_ptr_ctr
// Wrapping circular-buffer pointer, used for both the write and read side.
//   clk, rst_n   clock and asynchronous active-low reset (ptr -> 0)
//   inc          advance the pointer, wrapping at DEPTH-1 -> 0
//   clr          return the pointer to 0; takes priority over inc
//   ptr          current pointer, PW bits
// -----------------------------------------------------------------------------
module pipe_ptr_ctr
   import pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PW    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] ptr_nxt;

   always_comb begin
      ptr_nxt = ptr;
      if (clr) begin
         ptr_nxt = '0;
      end else if (inc) begin
         ptr_nxt = PW'(ptr_inc(32'(ptr), DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/pipe_elastic_stage.sv
// -----------------------------------------------------------------------------
// pipe_elastic_stage
// Elastic pipeline register between two CPU stages: a DEPTH-entry circular
// buffer of WIDTH-bit stage-state words with valid/ready handshake, hazard
// stall (hold) and branch/jump flush.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; drops all entries at once
//   up   (slave)   upstream channel: valid/data in, ready out
//   dn   (master)  downstream channel: valid/data out, ready in;
//                  data reads as zero (bubble) while valid is low
//   hold           freeze pops; pushes still accepted
//   flush          discard every entry and any same-cycle push
//   count          occupancy, $clog2(DEPTH+1) bits
//
// Build option
//   PIPE_STATS_EN  adds saturating stall_cycles / bubble_cycles counters
//
// up.ready depends only on registered occupancy, so there is no
// combinational path from dn.ready or hold back to the upstream stage.
// A pushed word appears on dn the cycle after its push edge (no bypass).
// -----------------------------------------------------------------------------
module pipe_elastic_stage
   import pipe_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipe_elastic_stage_if.slave   up,
   pipe_elastic_stage_if.master  dn,
   input  logic                  hold,
   input  logic                  flush,
`ifdef PIPE_STATS_EN
   output logic [31:0]           stall_cycles,
   output logic [31:0]           bubble_cycles,
`endif
   output logic [CW-1:0]         count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic [CW-1:0]    count_nxt;

   assign in_ready  = (count < DEPTH_C);
   assign out_valid = (count != '0);

   // Flush overrides both directions; hold only blocks the pop side.
   assign push = up.valid & in_ready & ~flush;
   assign pop  = out_valid & dn.ready & ~hold & ~flush;

   assign up.ready = in_ready;
   assign dn.valid = out_valid;
   assign dn.data  = out_valid ? mem[rd_ptr] : '0;

   pipe_ptr_ctr #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push),
      .clr   (flush),
      .ptr   (wr_ptr)
   );

   pipe_ptr_ctr #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop),
      .clr   (flush),
      .ptr   (rd_ptr)
   );

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // Storage is only cleared by reset; a flush just rewinds the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= up.data;
      end
   end

`ifdef PIPE_STATS_EN
   logic stall_evt;
   logic bubble_evt;

   assign stall_evt  = out_valid & (hold | ~dn.ready);
   assign bubble_evt = ~out_valid & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
      end else begin
         if (stall_evt && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (bubble_evt && (bubble_cycles != 32'hFFFF_FFFF)) begin
            bubble_cycles <= bubble_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_elastic_stage
// Directed bench for pipe_elastic_stage: a DEPTH=2 instance for the reset,
// fill/drain, streaming, hold, flush and async-reset cases and a DEPTH=3
// instance for pointer wrap under an irregular out_ready pattern.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_elastic_stage;

   logic clk;
   logic rst_n;
   logic hold2, flush2;
   logic hold3, flush3;
   logic [1:0] count2;
   logic [1:0] count3;
   int total;
   int fails;

   pipe_elastic_stage_if #(.WIDTH(32)) up2 ();
   pipe_elastic_stage_if #(.WIDTH(32)) dn2 ();
   pipe_elastic_stage_if #(.WIDTH(32)) up3 ();
   pipe_elastic_stage_if #(.WIDTH(32)) dn3 ();

`ifdef PIPE_STATS_EN
   logic [31:0] stall2, bubble2, stall3, bubble3;
`endif

   pipe_elastic_stage #(.WIDTH(32), .DEPTH(2)) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .up            (up2),
      .dn            (dn2),
      .hold          (hold2),
      .flush         (flush2),
`ifdef PIPE_STATS_EN
      .stall_cycles  (stall2),
      .bubble_cycles (bubble2),
`endif
      .count         (count2)
   );

   pipe_elastic_stage #(.WIDTH(32), .DEPTH(3)) dut3 (
      .clk           (clk),
      .rst_n         (rst_n),
      .up            (up3),
      .dn            (dn3),
      .hold          (hold3),
      .flush         (flush3),
`ifdef PIPE_STATS_EN
      .stall_cycles  (stall3),
      .bubble_cycles (bubble3),
`endif
      .count         (count3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] q[$];
      logic [9:0]  rdy_pat;
      logic [31:0] exp_head;
      logic        m_push, m_pop;
      int          stalls;
      logic [31:0] next_word;

      total = 0;
      fails = 0;
      rst_n = 1'b0;
      hold2 = 1'b0; flush2 = 1'b0;
      hold3 = 1'b0; flush3 = 1'b0;
      up2.valid = 1'b0; up2.data = '0; dn2.ready = 1'b0;
      up3.valid = 1'b0; up3.data = '0; dn3.ready = 1'b0;

      // 1. reset
      #3;
      chk("rst_out_valid", 32'(dn2.valid), 32'd0);
      chk("rst_out_data", dn2.data, 32'd0);
      chk("rst_count", 32'(count2), 32'd0);
      chk("rst_in_ready", 32'(up2.ready), 32'd1);
      chk("rst_in_ready3", 32'(up3.ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("idle_count", 32'(count2), 32'd0);
      chk("idle_out_valid", 32'(dn2.valid), 32'd0);

      // 2. fill to full, then drain
      up2.valid = 1'b1; up2.data = 32'hA1;
      tick();
      chk("fill1_count", 32'(count2), 32'd1);
      chk("fill1_data", dn2.data, 32'hA1);
      up2.data = 32'hB2;
      tick();
      up2.valid = 1'b0; up2.data = '0;
      chk("full_count", 32'(count2), 32'd2);
      chk("full_in_ready", 32'(up2.ready), 32'd0);
      chk("full_head", dn2.data, 32'hA1);
      dn2.ready = 1'b1;
      tick();
      chk("drain1_data", dn2.data, 32'hB2);
      chk("drain1_count", 32'(count2), 32'd1);
      tick();
      chk("drain2_count", 32'(count2), 32'd0);
      chk("drain2_valid", 32'(dn2.valid), 32'd0);
      chk("drain2_bubble", dn2.data, 32'd0);

      // 3. streaming
      for (int i = 0; i < 20; i++) begin
         up2.valid = 1'b1; up2.data = 32'(i);
         tick();
         chk("stream_data", dn2.data, 32'(i));
         chk("stream_count", 32'(count2), 32'd1);
      end
      up2.valid = 1'b0;
      tick();
      chk("stream_end_count", 32'(count2), 32'd0);

      // 4. hold
      dn2.ready = 1'b0;
      up2.valid = 1'b1; up2.data = 32'h55;
      tick();
      up2.valid = 1'b0;
      hold2 = 1'b1; dn2.ready = 1'b1;
      tick();
      chk("hold1_data", dn2.data, 32'h55);
      chk("hold1_count", 32'(count2), 32'd1);
      up2.valid = 1'b1; up2.data = 32'h66;
      tick();
      up2.valid = 1'b0;
      chk("hold2_data", dn2.data, 32'h55);
      chk("hold2_count", 32'(count2), 32'd2);
      tick();
      chk("hold3_data", dn2.data, 32'h55);
      chk("hold3_valid", 32'(dn2.valid), 32'd1);
      hold2 = 1'b0;
      tick();
      chk("unhold_data", dn2.data, 32'h66);
      chk("unhold_count", 32'(count2), 32'd1);
      tick();
      chk("unhold_empty", 32'(count2), 32'd0);

      // 5. flush while full, then flush against a push
      dn2.ready = 1'b0;
      up2.valid = 1'b1; up2.data = 32'h11;
      tick();
      up2.data = 32'h22;
      tick();
      chk("pre_flush_count", 32'(count2), 32'd2);
      flush2 = 1'b1; up2.data = 32'hFF; dn2.ready = 1'b1;
      tick();
      chk("flush_count", 32'(count2), 32'd0);
      chk("flush_valid", 32'(dn2.valid), 32'd0);
      chk("flush_data", dn2.data, 32'd0);
      chk("flush_in_ready", 32'(up2.ready), 32'd1);
      flush2 = 1'b0; up2.valid = 1'b0;
      tick();
      chk("post_flush_valid", 32'(dn2.valid), 32'd0);
      dn2.ready = 1'b0;
      up2.valid = 1'b1; up2.data = 32'h33;
      tick();
      chk("one_entry_data", dn2.data, 32'h33);
      flush2 = 1'b1; up2.data = 32'hFF;
      tick();
      chk("flush_push_count", 32'(count2), 32'd0);
      flush2 = 1'b0; up2.valid = 1'b0;
      tick();
      chk("flush_push_valid", 32'(dn2.valid), 32'd0);
      up2.valid = 1'b1; up2.data = 32'h77;
      tick();
      up2.valid = 1'b0;
      chk("after_flush_data", dn2.data, 32'h77);
      dn2.ready = 1'b1;
      tick();
      chk("after_flush_empty", 32'(count2), 32'd0);

      // 6. DEPTH=3 wrap with an irregular out_ready pattern (bit c = cycle c)
      rdy_pat   = 10'b11_0110_1000;
      stalls    = 0;
      next_word = 32'h40;
      for (int c = 0; c < 14; c++) begin
         up3.valid = 1'b1;
         up3.data  = next_word;
         dn3.ready = (c < 10) ? rdy_pat[c] : 1'b1;
         exp_head  = (q.size() != 0) ? q[0] : 32'd0;
         chk("wrap_count", 32'(count3), 32'(q.size()));
         chk("wrap_data", dn3.data, exp_head);
         chk("wrap_in_ready", 32'(up3.ready), (q.size() < 3) ? 32'd1 : 32'd0);
         m_push = (q.size() < 3);
         m_pop  = (q.size() != 0) && dn3.ready;
         if ((q.size() != 0) && !dn3.ready) stalls++;
         tick();
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            q.push_back(next_word);
            next_word = next_word + 32'd1;
         end
      end
      up3.valid = 1'b0;
`ifdef PIPE_STATS_EN
      chk("stall_cycles", stall3, 32'(stalls));
`endif

      // 7. async reset mid-transfer
      dn2.ready = 1'b0;
      up2.valid = 1'b1; up2.data = 32'h88;
      tick();
      up2.valid = 1'b0;
      chk("pre_rst_count", 32'(count2), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(count2), 32'd0);
      chk("async_rst_valid", 32'(dn2.valid), 32'd0);
      chk("async_rst_data", dn2.data, 32'd0);
      chk("async_rst_count3", 32'(count3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
